// File: rtl/chorus_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : chorus_sequencer_if
// Description : Stream and buffer-side signal bundle for chorus_sequencer.
//               Groups three things:
//                 - the input sample stream   (s_valid / s_ready / s_data)
//                 - the output sample stream  (m_valid / m_ready / m_data)
//                 - the delay-line buffer port (buf_enable / buf_data_in /
//                   buf_delay out, buf_dry / buf_wet back)
//               Modport "slave" is the sequencer's view of the bundle.
//               Modport "master" is the surrounding system: the sample
//               source, the sink and the buffer.
// Revision    : 1.0  initial release
// ============================================================================
interface chorus_sequencer_if;
  // Input sample stream (source -> sequencer)
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;

  // Output sample stream (sequencer -> sink)
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;

  // Delay-line buffer port
  logic        buf_enable;
  logic [15:0] buf_data_in;
  logic [15:0] buf_delay;
  logic [15:0] buf_dry;
  logic [15:0] buf_wet;

  modport slave (
    input  s_valid, s_data, m_ready, buf_dry, buf_wet,
    output s_ready, m_valid, m_data, buf_enable, buf_data_in, buf_delay
  );

  modport master (
    output s_valid, s_data, m_ready, buf_dry, buf_wet,
    input  s_ready, m_valid, m_data, buf_enable, buf_data_in, buf_delay
  );
endinterface
`default_nettype wire

// File: rtl/chorus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : chorus_sequencer
// Description : Per-sample controller for the chorus delay-line buffer.
//
//               For each accepted input sample the sequencer:
//                 1. issues one single-cycle buffer enable;
//                 2. captures the buffer's dry and delayed (wet) outputs;
//                 3. mixes them, or passes dry through in bypass;
//                 4. offers the result on an output stream.
//
//               The delay presented to the buffer follows a triangle LFO on
//               top of a configurable base delay, saturated to the buffer
//               depth.
//
// Ports       : clk, resetn    - clock, synchronous active-low reset
//               bus (slave)     - input stream, output stream, buffer port
//               cfg_min_delay   - base delay in samples
//               cfg_depth       - LFO peak offset in samples
//               cfg_rate        - accepted samples per LFO step, minus 1
//               cfg_bypass      - 1: output the dry sample unmixed
// Revision    : 1.0  initial release
// ============================================================================
module chorus_sequencer #(
  parameter int BUF_SIZE = 44100,
  parameter int RATE_W   = 16
) (
  input  wire logic              clk,
  input  wire logic              resetn,
  chorus_sequencer_if.slave      bus,
  input  wire logic [15:0]       cfg_min_delay,
  input  wire logic [15:0]       cfg_depth,
  input  wire logic [RATE_W-1:0] cfg_rate,
  input  wire logic              cfg_bypass
);

  // Largest delay the buffer can honour
  localparam logic [16:0] c_MAX_DELAY = 17'(BUF_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  state_t r_state;

  // Registered outputs
  logic        r_s_ready;
  logic        r_m_valid;
  logic [15:0] r_m_data;
  logic        r_buf_enable;
  logic [15:0] r_buf_data_in;
  logic [15:0] r_buf_delay;

  // Per-sample and LFO state
  logic              r_bypass;
  logic [15:0]       r_offset;
  logic              r_dir_down;
  logic [RATE_W-1:0] r_rate_cnt;

  // ---------------------------------------------------------------------
  // Delay computation.
  // The sum is formed in 17 bits so that base + offset cannot wrap
  // before the clamp is applied.
  // ---------------------------------------------------------------------
  logic [16:0] w_delay_sum;
  logic [15:0] w_delay_clamped;
  logic [15:0] w_min_clamped;

  assign w_delay_sum = {1'b0, cfg_min_delay} + {1'b0, r_offset};

  assign w_delay_clamped = (w_delay_sum > c_MAX_DELAY)
                           ? c_MAX_DELAY[15:0]
                           : w_delay_sum[15:0];

  // Reset clears the offset, so the reset delay is just the clamped base
  assign w_min_clamped = ({1'b0, cfg_min_delay} > c_MAX_DELAY)
                         ? c_MAX_DELAY[15:0]
                         : cfg_min_delay;

  // ---------------------------------------------------------------------
  // Mix: average of dry and wet.
  // Both inputs are sign-extended to 17 bits, so the sum cannot overflow.
  // Taking bits [16:1] is the arithmetic shift right by one.
  // ---------------------------------------------------------------------
  logic [16:0] w_mix_sum;
  logic [15:0] w_mix;

  assign w_mix_sum = {bus.buf_dry[15], bus.buf_dry}
                   + {bus.buf_wet[15], bus.buf_wet};

  assign w_mix = w_mix_sum[16:1];

  // ---------------------------------------------------------------------
  // Triangle step: next offset and direction if the LFO steps now.
  // ---------------------------------------------------------------------
  logic [15:0] w_step_offset;
  logic        w_step_down;
  logic        w_lfo_step;

  assign w_lfo_step = (r_rate_cnt == cfg_rate);

  always_comb begin
    w_step_offset = r_offset;
    w_step_down   = r_dir_down;

    if (cfg_depth == 16'd0) begin
      // No modulation: pin the offset at zero
      w_step_offset = 16'd0;
      w_step_down   = 1'b0;
    end else if (r_offset > cfg_depth) begin
      // Depth was reduced below the current offset: snap to the new peak
      // and head back down from there
      w_step_offset = cfg_depth;
      w_step_down   = 1'b1;
    end else if (!r_dir_down) begin
      if (r_offset >= cfg_depth - 16'd1) begin
        // Reaching the peak turns the sweep around
        w_step_offset = cfg_depth;
        w_step_down   = 1'b1;
      end else begin
        w_step_offset = r_offset + 16'd1;
      end
    end else begin
      if (r_offset <= 16'd1) begin
        // Reaching zero turns the sweep around
        w_step_offset = 16'd0;
        w_step_down   = 1'b0;
      end else begin
        w_step_offset = r_offset - 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_s_ready     <= 1'b0;
      r_m_valid     <= 1'b0;
      r_m_data      <= 16'd0;
      r_buf_enable  <= 1'b0;
      r_buf_data_in <= 16'd0;
      r_buf_delay   <= w_min_clamped;
      r_bypass      <= 1'b0;
      r_offset      <= 16'd0;
      r_dir_down    <= 1'b0;
      r_rate_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // The delay only tracks config/LFO here.
          // It therefore stays frozen across the buffer enable edge.
          r_buf_delay <= w_delay_clamped;
          r_s_ready   <= 1'b1;
          if (bus.s_valid && r_s_ready) begin
            r_buf_data_in <= bus.s_data;
            r_bypass      <= cfg_bypass;
            r_buf_enable  <= 1'b1;
            r_s_ready     <= 1'b0;
            r_state       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // The buffer samples its enable at the end of this cycle
          r_buf_enable <= 1'b0;
          r_state      <= S_CAPTURE;
        end

        S_CAPTURE: begin
          // Buffer outputs now reflect the sample written on the ISSUE edge
          r_m_data  <= r_bypass ? bus.buf_dry : w_mix;
          r_m_valid <= 1'b1;
          r_state   <= S_OUT;
        end

        S_OUT: begin
          if (bus.m_ready) begin
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_state   <= S_IDLE;
            if (w_lfo_step) begin
              r_rate_cnt <= '0;
              r_offset   <= w_step_offset;
              r_dir_down <= w_step_down;
            end else begin
              r_rate_cnt <= r_rate_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready     = r_s_ready;
  assign bus.m_valid     = r_m_valid;
  assign bus.m_data      = r_m_data;
  assign bus.buf_enable  = r_buf_enable;
  assign bus.buf_data_in = r_buf_data_in;
  assign bus.buf_delay   = r_buf_delay;

endmodule
`default_nettype wire

// File: tb/tb_chorus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_chorus_sequencer
// Description : Directed self-checking bench for chorus_sequencer.
//               The bench plays the buffer by driving buf_dry and buf_wet
//               directly, and plays both the sample source and the sink.
// Revision    : 1.0  initial release
// ============================================================================
module tb_chorus_sequencer;

  logic        clk;
  logic        resetn;
  logic [15:0] cfg_min_delay;
  logic [15:0] cfg_depth;
  logic [15:0] cfg_rate;
  logic        cfg_bypass;

  int n_cmp;
  int n_err;

  chorus_sequencer_if bus ();

  chorus_sequencer #(
    .BUF_SIZE (44100),
    .RATE_W   (16)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus.slave),
    .cfg_min_delay (cfg_min_delay),
    .cfg_depth     (cfg_depth),
    .cfg_rate      (cfg_rate),
    .cfg_bypass    (cfg_bypass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, then move off the edge before touching anything
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    bus.s_valid = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // One sample, sink ready.
  // Accept at edge k, enable during k..k+1, m_valid from edge k+2,
  // handshake at edge k+3.
  task automatic sample(
    input string       tag,
    input logic [15:0] d,
    input logic [15:0] dry,
    input logic [15:0] wet,
    input logic        bp,
    input logic [15:0] exp_m,
    input logic [15:0] exp_delay
  );
    chk({tag, ".rdy"}, 32'(bus.s_ready), 32'd1);
    bus.buf_dry = dry;
    bus.buf_wet = wet;
    cfg_bypass  = bp;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    tick();                                   // edge k: accept
    bus.s_valid = 1'b0;
    cfg_bypass  = ~bp;                        // bypass must have been latched
    chk({tag, ".en"},    32'(bus.buf_enable),  32'd1);
    chk({tag, ".din"},   32'(bus.buf_data_in), 32'(d));
    chk({tag, ".dly"},   32'(bus.buf_delay),   32'(exp_delay));
    chk({tag, ".srdy0"}, 32'(bus.s_ready),     32'd0);
    tick();                                   // edge k+1
    chk({tag, ".en1"}, 32'(bus.buf_enable), 32'd0);
    chk({tag, ".mv1"}, 32'(bus.m_valid),    32'd0);
    tick();                                   // edge k+2
    chk({tag, ".mv"}, 32'(bus.m_valid), 32'd1);
    chk({tag, ".md"}, 32'(bus.m_data),  32'(exp_m));
    tick();                                   // edge k+3: handshake
    chk({tag, ".mv0"}, 32'(bus.m_valid), 32'd0);
    cfg_bypass = 1'b0;
  endtask

  logic [15:0] exp_sweep [16] = '{16'd100, 16'd100, 16'd101, 16'd101,
                                  16'd102, 16'd102, 16'd103, 16'd103,
                                  16'd102, 16'd102, 16'd101, 16'd101,
                                  16'd100, 16'd100, 16'd101, 16'd101};

  logic [15:0] held_data;

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    resetn        = 1'b0;
    bus.s_valid   = 1'b1;
    bus.s_data    = 16'h5555;
    bus.m_ready   = 1'b1;
    bus.buf_dry   = 16'h0;
    bus.buf_wet   = 16'h0;
    cfg_min_delay = 16'd100;
    cfg_depth     = 16'd0;
    cfg_rate      = 16'd0;
    cfg_bypass    = 1'b0;

    // ---------------- Reset held 3 cycles with s_valid high ----------------
    repeat (3) tick();
    chk("rst.s_ready", 32'(bus.s_ready),    32'd0);
    chk("rst.buf_en",  32'(bus.buf_enable), 32'd0);
    chk("rst.m_valid", 32'(bus.m_valid),    32'd0);
    chk("rst.m_data",  32'(bus.m_data),     32'd0);
    chk("rst.buf_din", 32'(bus.buf_data_in), 32'd0);
    chk("rst.delay",   32'(bus.buf_delay),  32'd100);
    resetn      = 1'b1;
    bus.s_valid = 1'b0;
    tick();
    chk("rst.s_ready1", 32'(bus.s_ready), 32'd1);

    // ---------------- Single sample and signed mixes ----------------
    sample("mix1", 16'h1000, 16'h1000, 16'h0800, 1'b0, 16'h0C00, 16'd100);
    sample("mix2", 16'h8000, 16'h8000, 16'h8000, 1'b0, 16'h8000, 16'd100);
    sample("mix3", 16'h7FFF, 16'h7FFF, 16'h0001, 1'b0, 16'h4000, 16'd100);
    sample("mix4", 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'd100);
    sample("byp",  16'h1234, 16'h1234, 16'h5678, 1'b1, 16'h1234, 16'd100);

    // ---------------- Backpressure ----------------
    bus.m_ready = 1'b0;
    bus.buf_dry = 16'h0200;
    bus.buf_wet = 16'h0100;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h0200;
    tick();                                   // accept
    bus.s_valid = 1'b1;                       // source keeps offering
    tick();
    tick();
    chk("bp.mv",   32'(bus.m_valid), 32'd1);
    chk("bp.md",   32'(bus.m_data),  32'h0180);
    held_data = bus.m_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp.hold_mv",  32'(bus.m_valid),    32'd1);
      chk("bp.hold_md",  32'(bus.m_data),     32'h0180);
      chk("bp.hold_rdy", 32'(bus.s_ready),    32'd0);
      chk("bp.hold_en",  32'(bus.buf_enable), 32'd0);
    end
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b0;
    tick();                                   // handshake
    chk("bp.rel_mv",  32'(bus.m_valid), 32'd0);
    chk("bp.rel_rdy", 32'(bus.s_ready), 32'd1);
    tick();
    chk("bp.idle_en", 32'(bus.buf_enable), 32'd0);
    chk("bp.idle_mv", 32'(bus.m_valid),    32'd0);

    // ---------------- LFO sweep ----------------
    cfg_min_delay = 16'd100;
    cfg_depth     = 16'd3;
    cfg_rate      = 16'd1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      sample($sformatf("sweep%0d", i), 16'h0010, 16'h0010, 16'h0010, 1'b0,
             16'h0010, exp_sweep[i]);
    end

    // ---------------- Clamp ----------------
    cfg_min_delay = 16'd44098;
    cfg_depth     = 16'd5;
    cfg_rate      = 16'd0;
    do_reset();
    chk("clamp.rst_delay", 32'(bus.buf_delay), 32'd44098);
    sample("clamp0", 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'd44098);
    sample("clamp1", 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'd44099);
    sample("clamp2", 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'd44099);
    sample("clamp3", 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'd44099);

    // ---------------- Reset while in CAPTURE ----------------
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h0777;
    tick();                                   // accept -> ISSUE
    bus.s_valid = 1'b0;
    tick();                                   // -> CAPTURE
    resetn = 1'b0;
    tick();                                   // reset edge in CAPTURE
    chk("midrst.mv",    32'(bus.m_valid),    32'd0);
    chk("midrst.en",    32'(bus.buf_enable), 32'd0);
    chk("midrst.rdy",   32'(bus.s_ready),    32'd0);
    chk("midrst.delay", 32'(bus.buf_delay),  32'd44098);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst.no_mv", 32'(bus.m_valid), 32'd0);
    end
    // Offset cleared: first post-reset sample sees the bare base delay
    sample("midrst.s", 16'h0100, 16'h0100, 16'h0300, 1'b0, 16'h0200, 16'd44098);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Backstop against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/chorus_sequencer.md
Name: chorus_sequencer

Overview:
- Per-sample controller for the chorus delay-line buffer: accepts audio samples over a valid/ready stream and issues one single-cycle buffer enable per sample.
- Drives the buffer's delay input from a triangle LFO, captures the buffer's dry/delayed outputs, mixes them and presents the result on a valid/ready output stream.
- Sits between the audio sample source (stream/DMA side) and the DAC-side sink, wrapping the circular buffer inside the ChorusFilter IP.

Parameters:
- BUF_SIZE, 44100, buffer depth in samples; buf_delay never exceeds BUF_SIZE-1.
- RATE_W, 16, width of cfg_rate and the internal rate counter.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- s_valid  in  1  input sample valid
- s_ready  out  1  controller can accept a sample
- s_data  in  16  input sample, signed two's complement
- m_valid  out  1  output sample valid
- m_ready  in  1  sink accepts output
- m_data  out  16  mixed output sample, signed
- buf_enable  out  1  buffer enable strobe, one cycle per sample
- buf_data_in  out  16  sample written to the buffer
- buf_delay  out  16  delay in samples presented to the buffer
- buf_dry  in  16  buffer output 1 (current sample)
- buf_wet  in  16  buffer output 2 (delayed sample)
- cfg_min_delay  in  16  base delay in samples
- cfg_depth  in  16  LFO peak offset in samples
- cfg_rate  in  RATE_W  accepted samples per LFO step, minus 1
- cfg_bypass  in  1  1: m_data = dry sample

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE; s_ready=0 during the reset cycle, 1 on the first cycle after; m_valid=0, m_data=0, buf_enable=0, buf_data_in=0, buf_delay=cfg_min_delay clamped; LFO offset=0, direction=up, rate counter=0. Reset mid-sample aborts it; the sample is dropped, with no m_valid.
- FSM states: IDLE, ISSUE, CAPTURE, OUT.
- IDLE: s_ready=1. On s_valid&s_ready: register s_data into buf_data_in, latch cfg_bypass -> ISSUE.
- ISSUE: buf_enable=1 for exactly this cycle; buf_delay and buf_data_in held stable -> CAPTURE.
- CAPTURE: buf_dry/buf_wet are valid (the buffer updated on the ISSUE edge). Register m_data:
  - bypass=1: m_data = buf_dry.
  - otherwise: m_data = (sext17(buf_dry)+sext17(buf_wet)) >>> 1, arithmetic shift, truncate to 16 bits; no overflow possible.
  - Then -> OUT.
- OUT: m_valid=1, m_data held until m_ready. On m_valid&m_ready: update the LFO -> IDLE. m_valid deasserts on the following cycle.
- s_ready=0 in ISSUE, CAPTURE and OUT; buf_enable=0 outside ISSUE.
- Latency: accept edge k, buf_enable high during cycle k..k+1, m_valid high from edge k+2. Max throughput is one sample per 4 cycles with m_ready tied high.
- LFO update, once per output handshake:
  - If rate counter == cfg_rate: clear the counter and step the offset. Otherwise increment the counter.
  - cfg_rate=0 steps the offset every sample.
- Offset step, triangle:
  - Up: offset+1. When the result reaches cfg_depth, direction becomes down.
  - Down: offset-1. When the result reaches 0, direction becomes up.
  - cfg_depth=0: offset held at 0.
  - If cfg_depth drops below the current offset, offset is forced to cfg_depth and direction to down on the next step.
- buf_delay = min(cfg_min_delay + offset, BUF_SIZE-1), computed in 17 bits. It is registered and updated only in IDLE, never while in ISSUE, so the buffer sees a stable delay at its enable edge.
- Config inputs may change at any time; their effect is sampled as specified above (bypass at accept, depth/rate/min at LFO update and in IDLE).

Test Plan:
- Reset: hold resetn=0 for 3 cycles with s_valid=1 -> s_ready=0, buf_enable=0, m_valid=0, m_data=0; s_ready=1 one cycle after release.
- Single sample: cfg_bypass=0, s_data=0x1000, buffer model returns dry=0x1000, wet=0x0800 -> buf_enable exactly one cycle, m_valid at k+2, m_data=0x0C00.
- Signed mix: dry=0x8000, wet=0x8000 -> m_data=0x8000. Dry=0x7FFF, wet=0x0001 -> 0x4000. Bypass=1 with dry=0x1234 -> 0x1234.
- Backpressure: hold m_ready=0 for 10 cycles -> m_valid and m_data stable, s_ready=0, no further buf_enable; release -> one handshake, then IDLE.
- LFO sweep: min=100, depth=3, rate=1, 16 samples with m_ready=1 -> buf_delay sequence 100,100,101,101,102,102,103,103,102,102,101,101,100,100,101,101.
- Clamp and reset mid-operation: min=44098, depth=5 -> buf_delay saturates at 44099. Assert resetn=0 in CAPTURE -> no m_valid, offset=0.
